// File: rtl/motor_drive_sequencer_if.sv
// motor_drive_sequencer_if: request/status bundle between board I/O and the motor drive sequencer
//   sw_a, sw_b    : speed switches, level = number of bits set (0..3)
//   dir_req       : requested direction, bit0 motor A, bit1 motor B
//   ia, ib        : overcurrent comparators, synchronous to the sequencer clock
//   clear_btn     : fault clear request
//   width_a/b     : PWM compare widths (PWM high while cnt < width)
//   cnt           : shared PWM period counter
//   dir_a/b       : applied H-bridge direction bits
//   fault         : latched overcurrent indicator
//   busy_a/b      : channel is reversing (ramping down or in dead time)
//   master drives requests (board side), slave is the sequencer
interface motor_drive_sequencer_if #(
    parameter int WIDTH = 21
);
    logic [2:0]       sw_a;
    logic [2:0]       sw_b;
    logic [1:0]       dir_req;
    logic             ia;
    logic             ib;
    logic             clear_btn;
    logic [WIDTH-1:0] width_a;
    logic [WIDTH-1:0] width_b;
    logic [WIDTH-1:0] cnt;
    logic             dir_a;
    logic             dir_b;
    logic             fault;
    logic             busy_a;
    logic             busy_b;

    modport master (
        output sw_a, sw_b, dir_req, ia, ib, clear_btn,
        input  width_a, width_b, cnt, dir_a, dir_b, fault, busy_a, busy_b
    );

    modport slave (
        input  sw_a, sw_b, dir_req, ia, ib, clear_btn,
        output width_a, width_b, cnt, dir_a, dir_b, fault, busy_a, busy_b
    );
endinterface

// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer: ramped PWM widths, safe direction reversal and latched overcurrent shutdown for two motors
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : motor_drive_sequencer_if slave (switch/direction/overcurrent inputs,
//           widths, period counter, direction bits, fault and busy outputs)
module motor_drive_sequencer #(
    parameter int WIDTH        = 21,
    parameter int PERIOD_TOP   = 1666666,
    parameter int DUTY1        = 416666,
    parameter int DUTY2        = 833333,
    parameter int DUTY3        = 1250000,
    parameter int RAMP_STEP    = 104166,
    parameter int DEAD_PERIODS = 6,
    parameter int OC_FILTER    = 50000000
) (
    input  logic                    clock,
    input  logic                    reset,
    motor_drive_sequencer_if.slave  bus
);
    localparam int OCW = $clog2(OC_FILTER + 1);
    localparam int DW  = $clog2(DEAD_PERIODS + 1);

    typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD} state_t;

    logic [WIDTH-1:0] r_cnt;
    logic [OCW-1:0]   r_oc;
    logic             r_fault;
    logic             w_tick;
    logic             w_oc;
    logic             w_fault_set;
    logic             w_fault_clr;

    // One saturating step toward t; differences are compared so nothing can wrap or overshoot.
    function automatic logic [WIDTH-1:0] f_ramp(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] t);
        return w < t ? (t - w > WIDTH'(RAMP_STEP) ? w + WIDTH'(RAMP_STEP) : t)
                     : (w - t > WIDTH'(RAMP_STEP) ? w - WIDTH'(RAMP_STEP) : t);
    endfunction

    assign w_tick      = r_cnt == WIDTH'(PERIOD_TOP);
    assign w_oc        = bus.ia | bus.ib;
    // The filter count reaching OC_FILTER latches the fault on the following edge.
    assign w_fault_set = !r_fault && r_oc == OCW'(OC_FILTER);
    assign w_fault_clr = r_fault && bus.clear_btn && !w_oc;
    assign bus.cnt     = r_cnt;
    assign bus.fault   = r_fault;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_oc    <= '0;
            r_fault <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_oc    <= (r_fault || w_fault_set || !w_oc) ? '0 : r_oc + 1'b1;
            r_fault <= w_fault_set | (r_fault & !w_fault_clr);
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t           r_state;
        state_t           w_state;
        logic [WIDTH-1:0] r_width;
        logic [WIDTH-1:0] w_width;
        logic [WIDTH-1:0] w_target;
        logic [DW-1:0]    r_dead;
        logic [DW-1:0]    w_dead;
        logic [2:0]       w_sw;
        logic [1:0]       w_level;
        logic             r_dir;
        logic             w_dir;
        logic             w_req;

        assign w_sw     = (c == 0) ? bus.sw_a : bus.sw_b;
        assign w_req    = bus.dir_req[c];
        assign w_level  = 2'(w_sw[0]) + 2'(w_sw[1]) + 2'(w_sw[2]);
        assign w_target = w_level == 2'd3 ? WIDTH'(DUTY3) :
                          w_level == 2'd2 ? WIDTH'(DUTY2) :
                          w_level == 2'd1 ? WIDTH'(DUTY1) : '0;

        always_comb begin
            w_state = r_state;
            w_width = r_width;
            w_dead  = r_dead;
            w_dir   = r_dir;
            if (r_fault || w_fault_set) begin
                // Widths drop to zero on the same edge the fault latches; any reversal is aborted.
                w_state = RUN;
                w_width = '0;
                w_dead  = '0;
            end else begin
                case (r_state)
                    RUN: begin
                        w_width = w_tick ? f_ramp(r_width, w_target) : r_width;
                        w_state = w_req != r_dir ? RAMP_DOWN : RUN;
                    end
                    RAMP_DOWN: begin
                        w_width = w_tick ? f_ramp(r_width, '0) : r_width;
                        if (w_req == r_dir) begin
                            w_state = RUN;
                        end else if (r_width == '0) begin
                            w_state = DEAD;
                            w_dead  = '0;
                        end
                    end
                    default: begin
                        w_width = '0;
                        if (w_tick) begin
                            w_dead = r_dead + 1'b1;
                            // Last dead period: the bridge is idle, so the direction may flip now.
                            if (r_dead == DW'(DEAD_PERIODS - 1)) begin
                                w_dir   = w_req;
                                w_state = RUN;
                                w_dead  = '0;
                            end
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_state <= RUN;
                r_width <= '0;
                r_dead  <= '0;
                r_dir   <= 1'b0;
            end else begin
                r_state <= w_state;
                r_width <= w_width;
                r_dead  <= w_dead;
                r_dir   <= w_dir;
            end
        end

        if (c == 0) begin : g_a
            assign bus.width_a = r_width;
            assign bus.dir_a   = r_dir;
            assign bus.busy_a  = r_state != RUN;
        end else begin : g_b
            assign bus.width_b = r_width;
            assign bus.dir_b   = r_dir;
            assign bus.busy_b  = r_state != RUN;
        end
    end
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer: scoreboard bench for motor_drive_sequencer with a cycle-level reference model
`timescale 1ns/1ps
module tb_motor_drive_sequencer;
    localparam int W     = 21;
    localparam int TOP   = 99;
    localparam int D1    = 25;
    localparam int D2    = 50;
    localparam int D3    = 75;
    localparam int STEP  = 10;
    localparam int DEADP = 2;
    localparam int OCF   = 20;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic         da;
        logic         db;
        logic         flt;
        logic         ba;
        logic         bb;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    motor_drive_sequencer_if #(.WIDTH(W)) bus();

    motor_drive_sequencer #(
        .WIDTH(W), .PERIOD_TOP(TOP), .DUTY1(D1), .DUTY2(D2), .DUTY3(D3),
        .RAMP_STEP(STEP), .DEAD_PERIODS(DEADP), .OC_FILTER(OCF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t expq[$];

    // Reference model: width per motor, applied direction, whether a reversal is
    // pending, and remaining-dead-time bookkeeping (-1 = not in dead time).
    int duty[4] = '{0, D1, D2, D3};
    int m_cnt, m_oc;
    bit m_fault;
    int m_w[2];
    int m_dead[2];
    bit m_dir[2];
    bit m_rev[2];

    function automatic void model_reset();
        m_cnt = 0; m_oc = 0; m_fault = 0;
        for (int k = 0; k < 2; k++) begin
            m_w[k] = 0; m_dead[k] = -1; m_dir[k] = 0; m_rev[k] = 0;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.cnt = W'(m_cnt); o.wa = W'(m_w[0]); o.wb = W'(m_w[1]);
        o.da = m_dir[0]; o.db = m_dir[1]; o.flt = m_fault;
        o.ba = m_rev[0] || m_dead[0] >= 0;
        o.bb = m_rev[1] || m_dead[1] >= 0;
        return o;
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    function automatic void model_step();
        bit tick = m_cnt == TOP;
        bit oc   = bus.ia | bus.ib;
        bit fset = !m_fault && m_oc == OCF;
        bit fclr = m_fault && bus.clear_btn && !oc;
        for (int k = 0; k < 2; k++) begin
            int w0  = m_w[k];
            bit req = bus.dir_req[k];
            int tgt = duty[$countones(k == 0 ? bus.sw_a : bus.sw_b)];
            if (m_fault || fset) begin
                m_w[k] = 0; m_rev[k] = 0; m_dead[k] = -1;
            end else if (m_dead[k] >= 0) begin
                if (tick) m_dead[k]++;
                if (m_dead[k] == DEADP) begin
                    m_dir[k] = req; m_dead[k] = -1;
                end
            end else if (m_rev[k]) begin
                if (tick) m_w[k] = w0 > STEP ? w0 - STEP : 0;
                if (req == m_dir[k]) m_rev[k] = 0;
                else if (w0 == 0) begin
                    m_rev[k] = 0; m_dead[k] = 0;
                end
            end else begin
                if (tick) m_w[k] = w0 < tgt ? (w0 + STEP < tgt ? w0 + STEP : tgt)
                                            : (w0 - STEP > tgt ? w0 - STEP : tgt);
                if (req != m_dir[k]) m_rev[k] = 1;
            end
        end
        m_oc    = (m_fault || fset || !oc) ? 0 : m_oc + 1;
        m_fault = fset | (m_fault & !fclr);
        m_cnt   = tick ? 0 : m_cnt + 1;
    endfunction

    function automatic void check(string name, obs_t e);
        obs_t a;
        a = {bus.cnt, bus.width_a, bus.width_b, bus.dir_a, bus.dir_b, bus.fault, bus.busy_a, bus.busy_b};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got cnt=%0d wa=%0d wb=%0d dir=%0b%0b fault=%0b busy=%0b%0b, want cnt=%0d wa=%0d wb=%0d dir=%0b%0b fault=%0b busy=%0b%0b",
                     name, $time, a.cnt, a.wa, a.wb, a.da, a.db, a.flt, a.ba, a.bb,
                     e.cnt, e.wa, e.wb, e.da, e.db, e.flt, e.ba, e.bb);
        end
    endfunction

    function automatic void check_val(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endfunction

    // Monitor: every active edge presents a new output sample.
    initial forever begin
        @(posedge clock);
        #1;
        if (expq.size() > 0) check("cycle", expq.pop_front());
    end

    // Called at a falling edge with inputs settled; returns at the next falling edge.
    task automatic cycles(input int n);
        repeat (n) begin
            model_step();
            expq.push_back(model_obs());
            @(negedge clock);
        end
    endtask

    initial begin
        bus.sw_a = 3'b000; bus.sw_b = 3'b000; bus.dir_req = 2'b00;
        bus.ia = 1'b0; bus.ib = 1'b0; bus.clear_btn = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_state", '0);
        reset = 1'b0;

        bus.sw_a = 3'b111; bus.sw_b = 3'b011;
        cycles(1000);
        check_val("full_speed_a", int'(bus.width_a), 75);
        check_val("half_speed_b", int'(bus.width_b), 50);

        bus.sw_a = 3'b001;
        cycles(600);
        check_val("slow_down_a", int'(bus.width_a), 25);

        bus.sw_a = 3'b011;
        cycles(400);
        check_val("mid_speed_a", int'(bus.width_a), 50);
        bus.dir_req = 2'b01;
        cycles(200);
        check_val("reverse_busy_a", int'(bus.busy_a), 1);
        check_val("reverse_dir_held", int'(bus.dir_a), 0);
        cycles(1400);
        check_val("reverse_dir_a", int'(bus.dir_a), 1);
        check_val("reverse_done_a", int'(bus.busy_a), 0);
        check_val("reverse_width_a", int'(bus.width_a), 50);

        bus.dir_req = 2'b00;
        cycles(250);
        check_val("abort_busy_a", int'(bus.busy_a), 1);
        bus.dir_req = 2'b01;
        cycles(600);
        check_val("abort_idle_a", int'(bus.busy_a), 0);
        check_val("abort_dir_a", int'(bus.dir_a), 1);
        check_val("abort_width_a", int'(bus.width_a), 50);

        bus.ib = 1'b1;
        cycles(OCF - 1);
        bus.ib = 1'b0;
        cycles(5);
        check_val("oc_short_burst", int'(bus.fault), 0);
        bus.ib = 1'b1;
        cycles(OCF + 3);
        check_val("oc_fault_set", int'(bus.fault), 1);
        check_val("oc_width_a_zero", int'(bus.width_a), 0);
        bus.clear_btn = 1'b1;
        cycles(1);
        bus.clear_btn = 1'b0;
        cycles(3);
        check_val("oc_clear_blocked", int'(bus.fault), 1);
        bus.ib = 1'b0;
        cycles(2);
        bus.clear_btn = 1'b1;
        cycles(1);
        bus.clear_btn = 1'b0;
        cycles(2);
        check_val("oc_cleared", int'(bus.fault), 0);
        cycles(900);
        check_val("oc_recovered_a", int'(bus.width_a), 50);

        bus.dir_req = 2'b11;
        for (int i = 0; i < 3000 && m_dead[1] < 0; i++) cycles(1);
        cycles(30);
        check_val("dead_busy_b", int'(bus.busy_b), 1);
        check_val("dead_width_b", int'(bus.width_b), 0);
        #3;
        reset = 1'b1;
        bus.dir_req = 2'b00;
        #1;
        check("async_reset", '0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        cycles(5);
        check_val("post_reset_run_b", int'(bus.busy_b), 0);

        for (int s = 0; s < 40; s++) begin
            bus.sw_a = 3'($urandom);
            bus.sw_b = 3'($urandom);
            if ($urandom_range(0, 2) == 0) bus.dir_req = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.ia = 1'($urandom);
                bus.ib = !bus.ia || $urandom_range(0, 1) == 1;
                cycles($urandom_range(OCF - 5, OCF + 5));
                if ($urandom_range(0, 1) == 1) begin
                    bus.clear_btn = 1'b1;
                    cycles(1);
                    bus.clear_btn = 1'b0;
                end
                bus.ia = 1'b0;
                bus.ib = 1'b0;
            end
            if (m_fault && $urandom_range(0, 1) == 1) begin
                bus.clear_btn = 1'b1;
                cycles(1);
                bus.clear_btn = 1'b0;
            end
            cycles($urandom_range(50, 400));
        end

        @(posedge clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/motor_drive_sequencer.md
Name: motor_drive_sequencer

Overview:
- Sequencing controller for the dual-motor PWM datapath: converts switch-level speed requests and direction requests into ramped PWM compare widths and H-bridge direction bits.
- Enforces soft-start/soft-stop, ramp-to-zero plus dead time before any direction reversal, and a filtered, latched overcurrent shutdown with button clear.
- Sits between board switches/current-sense comparators and the PWM compare stage; it owns the PWM period counter and all ramp timing.

Parameters:
- WIDTH, 21, bit width of period counter and compare widths
- PERIOD_TOP, 1666666, terminal count of PWM period counter (period = PERIOD_TOP+1 clocks)
- DUTY1, 416666, width for speed level 1 (25%)
- DUTY2, 833333, width for speed level 2 (50%)
- DUTY3, 1250000, width for speed level 3 (75%)
- RAMP_STEP, 104166, width change per PWM period while ramping
- DEAD_PERIODS, 6, whole PWM periods at zero width before a direction bit changes
- OC_FILTER, 50000000, consecutive clocks of ia|ib high required to declare overcurrent

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sw_a  in  3  motor A speed switches; level = number of bits set (0..3)
- sw_b  in  3  motor B speed switches; same encoding
- dir_req  in  2  requested direction; bit0 motor A, bit1 motor B
- ia  in  1  motor A overcurrent comparator, synchronous to clock
- ib  in  1  motor B overcurrent comparator, synchronous to clock
- clear_btn  in  1  fault clear request
- width_a  out  WIDTH  motor A PWM compare width (PWM high while counter < width)
- width_b  out  WIDTH  motor B PWM compare width
- cnt  out  WIDTH  PWM period counter, shared by both PWM compare stages
- dir_a  out  1  applied motor A direction (drives IN1 = dir_a, IN2 = ~dir_a)
- dir_b  out  1  applied motor B direction
- fault  out  1  latched overcurrent indicator
- busy_a  out  1  motor A is in RAMP_DOWN or DEAD
- busy_b  out  1  motor B is in RAMP_DOWN or DEAD

Behaviour:
- Reset: cnt=0, width_a=width_b=0, dir_a=dir_b=0, fault=0, both channel FSMs in RUN, OC filter count 0.
- Period counter: cnt increments each clock and wraps PERIOD_TOP -> 0. Internal tick is high in the cycle where cnt==PERIOD_TOP. Ramps and dead-time counting advance only on tick.
- Target width: level 0 -> 0, 1 -> DUTY1, 2 -> DUTY2, 3 -> DUTY3. Inputs are sampled every clock.
- Ramp, on tick: if width<target, width = min(width+RAMP_STEP, target); if width>target, width = max(width-RAMP_STEP, target). Arithmetic saturates, with no wrap and no overshoot.
- Per-channel FSM (A and B identical and independent):
  - RUN: ramp toward the switch target. If the dir_req bit != dir output, go to RAMP_DOWN.
  - RAMP_DOWN: target forced to 0. If the dir_req bit returns to equal the dir output, go back to RUN (ramp up from the current width). When width==0, go to DEAD and clear the dead counter.
  - DEAD: width held 0. The dead counter increments on tick. When it reaches DEAD_PERIODS, the dir output is loaded with the dir_req bit sampled in that cycle, and the FSM returns to RUN, ramping up from 0.
  - busy = (state != RUN).
- Overcurrent filter: a counter increments each clock while (ia|ib) and resets to 0 the first clock ia|ib is low. When it reaches OC_FILTER, fault is set on the next clock edge.
- While fault=1:
  - width_a and width_b are forced to 0 in the same clock that fault is set.
  - Both FSMs are held in RUN with internal widths cleared.
  - dir outputs hold their values.
  - The filter counter is held at 0.
- Fault clear: clear_btn=1 with ia|ib=0 in the same clock clears fault on the next edge; widths then ramp up from 0 toward their targets. clear_btn is ignored while ia|ib=1. clear_btn has no effect while fault=0.
- Priority: fault > direction sequencing > speed ramp. A fault in RAMP_DOWN or DEAD aborts the sequence. After clear, a still-mismatched dir_req re-enters RAMP_DOWN, which passes directly to DEAD because width is 0.
- Level change mid-ramp: the new target takes effect from the next tick; the ramp reverses without a jump.
- Asynchronous reset mid-operation returns all state to its reset values immediately.

Test Plan:
(bench parameters: PERIOD_TOP=99, DUTY1=25, DUTY2=50, DUTY3=75, RAMP_STEP=10, DEAD_PERIODS=2, OC_FILTER=20)
1. Release reset, sw_a=3'b111 -> width_a after successive ticks reads 10,20,...,70, then 75 at tick 8 and holds. cnt wraps 99->0 every 100 clocks.
2. From width_a=75, sw_a=3'b001 -> width_a reads 65,55,45,35, then 25 at tick 5; no undershoot.
3. Run at width_a=50, dir_a=0, set dir_req[0]=1 -> busy_a=1, width ramps 40..0, then 2 ticks at 0, then dir_a=1, busy_a=0, and width ramps back to 50. dir_a never toggles while width_a != 0.
4. During RAMP_DOWN, return dir_req[0] to 0 -> FSM returns to RUN, dir_a stays 0, width ramps up from its current value.
5. Hold ib=1 for 19 clocks then drop -> no fault. Hold ib=1 for 20 clocks -> fault=1 and width_a=width_b=0 on the next edge. Pulse clear_btn with ib=1 -> fault stays 1. Drop ib, pulse clear_btn -> fault=0 and widths ramp up from 0.
6. Assert reset in DEAD with fault=0 -> all outputs return to reset values immediately; state is RUN after release.
